// File: rtl/mine_count_engine.sv
// mine_count_engine
//   Latches a 5x5 mine bitmap and walks it one cell per valid/ready handshake.
//   Each cell record carries the cell index, its mine bit and the number of
//   mines among its in-bounds neighbours. Mines are tallied over accepted cells
//   and compared with the requested count when the scan finishes.
//
// Ports
//   in_clka          clock, rising edge
//   in_rst_n         asynchronous active-low reset
//   in_load          start a scan (sampled in IDLE only)
//   in_mines         mine bitmap, bit i = cell i = row*COLS+col
//   in_mines_num     expected mine count, latched with in_load
//   out_busy         high while scanning or done
//   out_cell_valid   cell record valid
//   in_cell_ready    consumer accepts record on valid & ready
//   out_cell_idx     cell index
//   out_cell_mine    mine bit of the presented cell
//   out_cell_count   neighbour mine count 0..8
//   out_done         one-cycle pulse after the last cell is accepted
//   out_mines_total  mines counted over accepted cells
//   out_count_ok     tally matches the latched expected count (valid with out_done)

module mine_count_engine #(
    parameter int unsigned ROWS = 5,
    parameter int unsigned COLS = 5
) (
    input  logic                 in_clka,
    input  logic                 in_rst_n,
    input  logic                 in_load,
    input  logic [ROWS*COLS-1:0] in_mines,
    input  logic [4:0]           in_mines_num,
    output logic                 out_busy,
    output logic                 out_cell_valid,
    input  logic                 in_cell_ready,
    output logic [4:0]           out_cell_idx,
    output logic                 out_cell_mine,
    output logic [3:0]           out_cell_count,
    output logic                 out_done,
    output logic [4:0]           out_mines_total,
    output logic                 out_count_ok
);

    localparam int NRows   = int'(ROWS);
    localparam int NCols   = int'(COLS);
    localparam int LastIdx = NRows * NCols - 1;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                 state_q;
    logic [ROWS*COLS-1:0]   map_q;
    logic [4:0]             num_q;
    logic [4:0]             idx_q;
    logic [4:0]             total_q;
    logic                   valid_q;
    logic                   done_q;
    logic                   ok_q;

    logic                   cur_mine;
    logic [4:0]             total_nxt;
    logic [3:0]             nbr_cnt;

    assign cur_mine  = map_q[idx_q];
    assign total_nxt = total_q + {4'b0000, cur_mine};

    // Neighbour count: visit the 3x3 window around the current cell and keep
    // only in-bounds positions, so there is no wrap across row ends or board edges.
    always_comb begin
        int row;
        int col;
        int r;
        int c;
        logic [4:0] nidx;
        nbr_cnt = '0;
        row     = int'(idx_q) / NCols;
        col     = int'(idx_q) % NCols;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r    = row + dr;
                c    = col + dc;
                nidx = 5'(r * NCols + c);
                if (!(dr == 0 && dc == 0) && r >= 0 && r < NRows && c >= 0 && c < NCols) begin
                    nbr_cnt = nbr_cnt + {3'b000, map_q[nidx]};
                end
            end
        end
    end

    always_ff @(posedge in_clka or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= StIdle;
            map_q   <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            total_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ok_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_load) begin
                        map_q   <= in_mines;
                        num_q   <= in_mines_num;
                        idx_q   <= '0;
                        total_q <= '0;
                        valid_q <= 1'b0;
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    // First SCAN cycle only raises valid, so cell 0 is presented
                    // one cycle after the load edge and done lands 26 cycles later.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (in_cell_ready) begin
                        total_q <= total_nxt;
                        if (idx_q == 5'(LastIdx)) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            ok_q    <= (total_nxt == num_q);
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out_busy        = (state_q != StIdle);
    assign out_cell_valid  = valid_q;
    assign out_cell_idx    = valid_q ? idx_q : 5'd0;
    assign out_cell_mine   = valid_q & cur_mine;
    assign out_cell_count  = valid_q ? nbr_cnt : 4'd0;
    assign out_done        = done_q;
    assign out_mines_total = total_q;
    assign out_count_ok    = ok_q;

endmodule

// File: doc/mine_count_engine.md
# mine_count_engine

Reads the 25-bit mine bitmap produced by the mine-placement RNG and walks the 5x5 board one cell per handshake. For each cell it emits the cell index, the cell's mine bit, and the number of mines among its up-to-8 neighbours. It also tallies total mines and checks the tally against the requested mine count. It sits between mine placement and the board display/reveal logic, and is the sole reader of the placement result.

## Interface
- ROWS, 5, board rows (fixed; bitmap width = ROWS*COLS = 25)
- COLS, 5, board columns (fixed)
- in_clka  input  1  clock; all state updates on rising edge
- in_rst_n  input  1  reset, asynchronous, active-low
- in_load  input  1  load request; sampled only in IDLE
- in_mines  input  25  mine bitmap; bit i = cell i, i = row*5+col, row 0 = bits 4:0
- in_mines_num  input  5  expected mine count, latched with in_load
- out_busy  output  1  high in SCAN and DONE
- out_cell_valid  output  1  cell record valid
- in_cell_ready  input  1  consumer accepts record when valid & ready
- out_cell_idx  output  5  cell index 0..24
- out_cell_mine  output  1  mine bit of current cell
- out_cell_count  output  4  neighbour mine count 0..8, excluding the cell itself
- out_done  output  1  one-cycle pulse after last cell accepted
- out_mines_total  output  5  mines counted over accepted cells
- out_count_ok  output  1  out_mines_total == latched in_mines_num; meaningful while out_done=1

## Operation
- States:
  - IDLE: waits for a load.
  - SCAN: steps through cells.
  - DONE: holds for one cycle, then returns to IDLE.
- IDLE -> SCAN: on in_load=1. On this edge:
  - latch in_mines into map_q and in_mines_num into num_q;
  - set idx_q=0 and total_q=0.
- SCAN:
  - out_cell_valid=1; out_cell_idx=idx_q; out_cell_mine=map_q[idx_q].
  - out_cell_count is computed combinationally from map_q around idx_q.
  - On valid & ready: total_q += map_q[idx_q].
    - If idx_q==24, go to DONE.
    - Otherwise idx_q += 1.
- DONE: out_done=1; out_count_ok = (total_q==num_q). Next state is IDLE.
- Neighbour rules:
  - Row = idx/5, col = idx%5.
  - A neighbour is counted only if its row and col lie in 0..4.
  - No wrap across row ends (idx 4 and idx 5 are not neighbours) and no wrap across top/bottom.
- Maximum counts: corner 3, edge 5, interior 8. The 4-bit result never overflows.
- total_q is 5 bits; the maximum value 25 fits.
- in_load outside IDLE (SCAN or DONE) is ignored. map_q and num_q stay unchanged.
- in_mines changing after the load edge has no effect.
- Reset (any state, including mid-SCAN):
  - state=IDLE; idx_q, total_q, map_q, num_q = 0.
  - All outputs 0.
  - A partially delivered scan is abandoned with no out_done.

## Timing
- Load sampled at edge k. out_cell_valid=1 with idx 0 from edge k+1.
- With in_cell_ready held high: one cell per cycle, idx 0..24 on edges k+1..k+25. out_done=1 for the cycle after edge k+26; this is 26 cycles from load to done.
- Backpressure: while valid=1 and ready=0, out_cell_idx, out_cell_mine and out_cell_count hold stable. valid does not drop until the handshake completes.
- out_cell_valid=0 in IDLE and DONE. out_done=0 outside DONE.
- out_mines_total updates on each accepted handshake and holds its final value through DONE and IDLE until the next load clears it.
- out_count_ok is 0 outside DONE.
- Earliest reload: in_load in the first IDLE cycle after DONE, i.e. back-to-back scans with a 1-cycle gap.

## Test plan
- All-zero map, in_mines_num=0, ready=1:
  - 25 records, idx 0..24 in order, all mine=0 and count=0.
  - out_done in cycle 26 after load; total=0; count_ok=1.
- Single mine at idx 12, num=1:
  - idx 6,7,8,11,13,16,17,18 give count=1; all others count=0.
  - idx 12 gives mine=1, count=0.
  - total=1; count_ok=1.
- Row-wrap check, mine at idx 4, num=2 (deliberately wrong):
  - idx 3,8,9 give count=1; idx 5 gives count=0.
  - total=1; count_ok=0.
- All-ones map, num=25:
  - idx 0,4,20,24 give count=3; idx 1,5,9,23 give count=5; idx 12 gives count=8.
  - total=25; count_ok=1.
- Backpressure, ready pattern 1,0,0,1,0,1... across the scan:
  - exactly 25 handshakes in index order;
  - outputs stable during every stall;
  - done only after handshake on idx 24.
- Reset and ignored load:
  - pulse in_load with a new map during SCAN at idx 10 -> ignored; scan continues with the original map.
  - assert in_rst_n=0 at idx 15 -> all outputs 0 immediately, no out_done.
  - after release, a new load starts at idx 0 with total cleared.
